// File: rtl/ctrl_pipe_if.sv
// Control-pipeline bundle: decode-stage control word in, E/M/W stage control
// and hazard-unit feedback out.
interface ctrl_pipe_if #(
    parameter int CNT_W = 32
);
    logic             ValidD;
    logic             RegWriteD;
    logic             MemtoRegD;
    logic             MemWriteD;
    logic             ALUSrcD;
    logic             RegDstD;
    logic [2:0]       ALUControlD;
    logic [4:0]       RsD;
    logic [4:0]       RtD;
    logic [4:0]       RdD;
    logic             FlushE;
    logic             CntClr;

    logic             RegWriteE;
    logic             MemtoRegE;
    logic             MemWriteE;
    logic             ALUSrcE;
    logic             RegDstE;
    logic [2:0]       ALUControlE;
    logic [4:0]       RsE;
    logic [4:0]       RtE;
    logic [4:0]       RdE;
    logic [4:0]       WriteRegE;
    logic             RegWriteM;
    logic             MemtoRegM;
    logic             MemWriteM;
    logic [4:0]       WriteRegM;
    logic             RegWriteW;
    logic             MemtoRegW;
    logic [4:0]       WriteRegW;
    logic             ValidE;
    logic             ValidM;
    logic             ValidW;
    logic [CNT_W-1:0] Retired;

    modport master (
        output ValidD, RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD,
               ALUControlD, RsD, RtD, RdD, FlushE, CntClr,
        input  RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE,
               RsE, RtE, RdE, WriteRegE, RegWriteM, MemtoRegM, MemWriteM,
               WriteRegM, RegWriteW, MemtoRegW, WriteRegW, ValidE, ValidM,
               ValidW, Retired
    );

    modport slave (
        input  ValidD, RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD,
               ALUControlD, RsD, RtD, RdD, FlushE, CntClr,
        output RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE,
               RsE, RtE, RdE, WriteRegE, RegWriteM, MemtoRegM, MemWriteM,
               WriteRegM, RegWriteW, MemtoRegW, WriteRegW, ValidE, ValidM,
               ValidW, Retired
    );
endinterface

// File: rtl/ctrl_pipe.sv
// E/M/W control register banks for the 5-stage MIPS core, plus a counter of
// instructions retiring out of W.
module ctrl_pipe #(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        resetn,
    ctrl_pipe_if.slave  bus
);
    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_dst;
        logic [2:0] alu_ctrl;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
    } e_bank_t;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic [4:0] write_reg;
    } m_bank_t;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_to_reg;
        logic [4:0] write_reg;
    } w_bank_t;

    e_bank_t          r_e;
    m_bank_t          r_m;
    w_bank_t          r_w;
    logic [CNT_W-1:0] r_retired;

    e_bank_t          w_e_d;
    logic [4:0]       w_write_reg_e;

    assign w_e_d = '{valid:      bus.ValidD,
                     reg_write:  bus.RegWriteD,
                     mem_to_reg: bus.MemtoRegD,
                     mem_write:  bus.MemWriteD,
                     alu_src:    bus.ALUSrcD,
                     reg_dst:    bus.RegDstD,
                     alu_ctrl:   bus.ALUControlD,
                     rs:         bus.RsD,
                     rt:         bus.RtD,
                     rd:         bus.RdD};

    assign w_write_reg_e = r_e.reg_dst ? r_e.rd : r_e.rt;

    // NOTE: non-blocking assignments let every bank sample the previous
    // stage's old value on the same edge, which is what makes this a pipeline.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_e       <= '0;
            r_m       <= '0;
            r_w       <= '0;
            r_retired <= '0;
        end else begin
            // A flushed bubble also clears Rs/Rt/Rd so it never forwards.
            r_e <= bus.FlushE ? '0 : w_e_d;

            r_m.valid      <= r_e.valid;
            r_m.reg_write  <= r_e.reg_write & (w_write_reg_e != 5'd0);
            r_m.mem_to_reg <= r_e.mem_to_reg;
            r_m.mem_write  <= r_e.mem_write;
            r_m.write_reg  <= w_write_reg_e;

            r_w.valid      <= r_m.valid;
            r_w.reg_write  <= r_m.reg_write;
            r_w.mem_to_reg <= r_m.mem_to_reg;
            r_w.write_reg  <= r_m.write_reg;

            if (bus.CntClr)
                r_retired <= '0;
            else if (r_w.valid)
                r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign bus.RegWriteE   = r_e.reg_write;
    assign bus.MemtoRegE   = r_e.mem_to_reg;
    assign bus.MemWriteE   = r_e.mem_write;
    assign bus.ALUSrcE     = r_e.alu_src;
    assign bus.RegDstE     = r_e.reg_dst;
    assign bus.ALUControlE = r_e.alu_ctrl;
    assign bus.RsE         = r_e.rs;
    assign bus.RtE         = r_e.rt;
    assign bus.RdE         = r_e.rd;
    assign bus.WriteRegE   = w_write_reg_e;
    assign bus.ValidE      = r_e.valid;
    assign bus.RegWriteM   = r_m.reg_write;
    assign bus.MemtoRegM   = r_m.mem_to_reg;
    assign bus.MemWriteM   = r_m.mem_write;
    assign bus.WriteRegM   = r_m.write_reg;
    assign bus.ValidM      = r_m.valid;
    assign bus.RegWriteW   = r_w.reg_write;
    assign bus.MemtoRegW   = r_w.mem_to_reg;
    assign bus.WriteRegW   = r_w.write_reg;
    assign bus.ValidW      = r_w.valid;
    assign bus.Retired     = r_retired;
endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Execute/memory/writeback control pipeline for the 5-stage MIPS core. Registers the decode-stage control word and register specifiers produced by the decode controller into the E, M and W stages. Returns RegWriteE/M/W, MemtoRegE/M, RsE/RtE and WriteRegE/M/W to the hazard unit, and drives the datapath's stage-local control. Also keeps a retired-instruction counter fed by a per-stage valid bit.

## Interface

Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  core clock, all state updates on rising edge
- resetn  in  1  reset, synchronous, active-low
- ValidD  in  1  decode stage holds a real instruction (0 = bubble)
- RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD  in  1 each  decode control
- ALUControlD  in  3  decode ALU control
- RsD, RtD, RdD  in  5 each  decode register specifiers
- FlushE  in  1  turn the E stage into a bubble on this edge
- CntClr  in  1  synchronous clear of retired counter
- RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE  out  1 each  E-stage control
- ALUControlE  out  3  E-stage ALU control
- RsE, RtE, RdE  out  5 each  E-stage specifiers
- WriteRegE  out  5  combinational: RegDstE ? RdE : RtE
- RegWriteM, MemtoRegM, MemWriteM  out  1 each  M-stage control
- WriteRegM  out  5  M-stage destination
- RegWriteW, MemtoRegW  out  1 each  W-stage control
- WriteRegW  out  5  W-stage destination
- ValidE, ValidM, ValidW  out  1 each  stage occupancy
- Retired  out  CNT_W  count of instructions leaving W

## Operation

- Three register banks: D→E, E→M, M→W. Every bank loads every cycle. There is no stage-E/M/W stall, so the back end never stalls.
- D→E load priority: reset > FlushE > normal.
  - On FlushE, all E fields are loaded with 0, including ValidE, RsE, RtE and RdE. Clearing the specifiers keeps the bubble from matching any forwarding comparison.
  - On a normal load, the bank captures the D inputs unchanged.
- The hazard unit asserts FlushE whenever StallD is asserted. This block does not see StallD and needs no hold path.
- E→M: ValidM←ValidE, MemtoRegM←MemtoRegE, MemWriteM←MemWriteE, WriteRegM←WriteRegE.
  - RegWriteM←RegWriteE & (WriteRegE != 0): writes to $0 are dropped here.
  - RegWriteE itself is not gated.
- M→W: straight copy of ValidM, RegWriteM, MemtoRegM, WriteRegM.
- Retired counter:
  - CntClr=1 loads 0. This wins over a simultaneous increment.
  - Otherwise the counter increments by 1 when ValidW=1.
  - Wraps modulo 2^CNT_W with no saturation or flag.
- A bubble (ValidX=0) always has RegWrite=MemWrite=MemtoReg=0 when it was created by flush or reset. Bubbles from ValidD=0 carry whatever control D presented; the decode controller guarantees zeros.

## Timing

- Latency D→E, E→M and M→W: 1 cycle each. A D-stage word reaches W 3 edges later.
- WriteRegE is combinational from the E registers, with no added register.
- On a clk edge with resetn=0, every registered output goes to 0. This covers all E/M/W control, specifiers, destinations, valid bits and Retired. WriteRegE consequently reads 0.
- Reset mid-operation discards all in-flight instructions. The first post-reset load takes D inputs on the first edge with resetn=1.
- FlushE affects only the E bank on that edge. The instruction already in E still advances to M on the same edge.
- CntClr on the same edge as ValidW=1: Retired=0 after the edge. The instruction in W is not counted.
- Retired at all-ones with ValidW=1 and CntClr=0: goes to 0 after the edge.

## Test plan

- Reset: hold resetn=0 for 2 edges with all D inputs = 1 and ValidD=1 → every output = 0. Release reset → D word appears at E after 1 edge, at M after 2, at W after 3.
- Walk-through: lw with RegWriteD=1, MemtoRegD=1, RegDstD=0, RtD=8, RdD=3, ValidD=1 → WriteRegE=8, then WriteRegM=8/RegWriteM=1/MemtoRegM=1, then WriteRegW=8/RegWriteW=1. Retired increments exactly once.
- Flush: present an add to $5 (RegDstD=1, RdD=5) with FlushE=1 → after the edge RegWriteE=0, RsE=RtE=RdE=0, ValidE=0. The preceding E instruction appears in M unchanged. Retired does not count the bubble.
- $0 suppression: R-type with RegWriteD=1, RegDstD=1, RdD=0 → RegWriteE=1 and WriteRegE=0, then RegWriteM=0 and RegWriteW=0. Retired still counts it (ValidW=1).
- Counter edges: CNT_W=4, preload 15 via 15 retired instructions, then one more → Retired=0. Then CntClr=1 with ValidW=1 → Retired stays 0.
- Back-to-back: 10 consecutive valid instructions with alternating FlushE → E/M/W sequences match the reference model every cycle. Retired=5 after drain.
